// File: rtl/multi_pulse_width_detector.sv
// ---------------------------------------------------------------------------
// multi_pulse_width_detector
//
// Per-channel pulse-width classifier. Each of N_CH single-bit inputs is
// polarity-adjusted (b = a ^ pol) and the length of every active run is
// counted. When a run ends, the measured width is reported and checked
// against a shared [min_w, max_w] window. Runs longer than MAX_W saturate
// at MAX_W+1 and are flagged as too_long instead of being detected.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst       in   1            synchronous active-high reset
//   a         in   N_CH         raw channel inputs
//   pol       in   N_CH         per-channel polarity (1 = low-going pulses)
//   min_w     in   CNT_W        minimum accepted width (shared)
//   max_w     in   CNT_W        maximum accepted width (shared)
//   rise      out  N_CH         effective input just became active
//   fall      out  N_CH         effective input just became inactive
//   detected  out  N_CH         pulse ended with width inside the window
//   too_long  out  N_CH         pulse ended with saturated width
//   width     out  N_CH*CNT_W   width of the ending pulse, channel i at
//                               [i*CNT_W +: CNT_W], zero when not falling
// ---------------------------------------------------------------------------
module multi_pulse_width_detector #(
    parameter int N_CH  = 4,
    parameter int MAX_W = 8,
    parameter int CNT_W = $clog2(MAX_W + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         pol,
    input  logic [CNT_W-1:0]        min_w,
    input  logic [CNT_W-1:0]        max_w,
    output logic [N_CH-1:0]         rise,
    output logic [N_CH-1:0]         fall,
    output logic [N_CH-1:0]         detected,
    output logic [N_CH-1:0]         too_long,
    output logic [N_CH*CNT_W-1:0]   width
);

    // Saturation value: one past the largest exactly measurable width.
    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_W + 1);

    logic [N_CH-1:0]  w_b;
    logic [N_CH-1:0]  r_b;
    logic [CNT_W-1:0] r_cnt [N_CH];

    assign w_b = a ^ pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_b <= w_b;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (w_b[i]) begin
                    // Hold at SAT so over-length pulses can never wrap back
                    // into the acceptance window.
                    r_cnt[i] <= (r_cnt[i] == SAT) ? SAT : r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Zero-latency classification: everything is decided in the first
    // inactive cycle from the count accumulated up to the previous cycle.
    always_comb begin
        rise     = '0;
        fall     = '0;
        detected = '0;
        too_long = '0;
        width    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rise[i]     = w_b[i] & ~r_b[i];
            fall[i]     = ~w_b[i] & r_b[i];
            too_long[i] = fall[i] && (r_cnt[i] == SAT);
            detected[i] = fall[i] && !too_long[i]
                          && (r_cnt[i] >= min_w) && (r_cnt[i] <= max_w);
            width[i*CNT_W +: CNT_W] = fall[i] ? r_cnt[i] : '0;
        end
    end

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_pulse_width_detector
//
// Directed bench for multi_pulse_width_detector (N_CH=4, MAX_W=8, CNT_W=4).
// A cycle-by-cycle vector table covers reset, window classification,
// polarity, reset mid-pulse, simultaneous channels and an empty window.
// Long and saturating pulses are driven by a hand-written pulse task.
// ---------------------------------------------------------------------------
module tb_multi_pulse_width_detector;

    localparam int N_CH  = 4;
    localparam int MAX_W = 8;
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       a;
    logic [N_CH-1:0]       pol;
    logic [CNT_W-1:0]      min_w;
    logic [CNT_W-1:0]      max_w;
    logic [N_CH-1:0]       rise;
    logic [N_CH-1:0]       fall;
    logic [N_CH-1:0]       detected;
    logic [N_CH-1:0]       too_long;
    logic [N_CH*CNT_W-1:0] width;

    int checks = 0;
    int errors = 0;

    multi_pulse_width_detector #(
        .N_CH  (N_CH),
        .MAX_W (MAX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .pol      (pol),
        .min_w    (min_w),
        .max_w    (max_w),
        .rise     (rise),
        .fall     (fall),
        .detected (detected),
        .too_long (too_long),
        .width    (width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  a;
        logic [3:0]  pol;
        logic [3:0]  mn;
        logic [3:0]  mx;
        logic [3:0]  er;
        logic [3:0]  ef;
        logic [3:0]  ed;
        logic [3:0]  et;
        logic [15:0] ew;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] av, input logic [3:0] pv,
                                input logic [3:0] mn, input logic [3:0] mx,
                                input logic [3:0] er, input logic [3:0] ef,
                                input logic [3:0] ed, input logic [3:0] et,
                                input logic [15:0] ew);
        vec_t v;
        v.rst = r; v.a = av; v.pol = pv; v.mn = mn; v.mx = mx;
        v.er = er; v.ef = ef; v.ed = ed; v.et = et; v.ew = ew;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [3:0] er, input logic [3:0] ef,
                             input logic [3:0] ed, input logic [3:0] et,
                             input logic [15:0] ew);
        check("rise",     idx, {12'h0, rise},     {12'h0, er});
        check("fall",     idx, {12'h0, fall},     {12'h0, ef});
        check("detected", idx, {12'h0, detected}, {12'h0, ed});
        check("too_long", idx, {12'h0, too_long}, {12'h0, et});
        check("width",    idx, width,             ew);
    endtask

    // Drive a single pulse of len cycles on channel ch (pol=0), then one
    // inactive cycle where the classification is checked, then one idle cycle.
    task automatic run_pulse(input int ch, input int len,
                             input logic [3:0] mn, input logic [3:0] mx,
                             input logic exp_det, input logic exp_tl,
                             input logic [3:0] exp_w, input int tag);
        logic [3:0]  m;
        logic [15:0] wexp;
        m    = 4'(1 << ch);
        wexp = 16'(exp_w) << (ch * CNT_W);
        min_w = mn;
        max_w = mx;
        pol   = 4'h0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            a = m;
            #2;
            check("pulse_rise", tag + k, {12'h0, rise}, (k == 0) ? {12'h0, m} : 16'h0);
            check("pulse_nofall", tag + k, {12'h0, fall}, 16'h0);
        end
        @(negedge clk);
        a = 4'h0;
        #2;
        check_all(tag + 100, 4'h0, m, exp_det ? m : 4'h0, exp_tl ? m : 4'h0, wexp);
        @(negedge clk);
        #2;
        check_all(tag + 200, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b1; a = '0; pol = '0; min_w = '0; max_w = '0;

        //  rst a    pol  mn   mx   rise fall det  tl   width
        // Reset: rise follows b, everything else is held low.
        add(1, 4'hF, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // ch0 single-cycle pulse, window [1,1].
        add(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0001);
        add(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // ch1 widths 1, 3, 5 with window [2,4].
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h2, 4'h2, 4'h0, 16'h0030);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0050);
        // ch3 low-going: a3 = 1 1 0 0 1 with pol3=1, window [2,2].
        add(0, 4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h8, 4'h2, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 16'h2000);
        add(0, 4'h8, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // Same waveform with pol3=0 on a line already high beforehand:
        // the high run is 3 long and the trailing pulse is 1 long, neither in [2,2].
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0, 4'h0, 16'h3000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0, 4'h0, 16'h1000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // Reset in the middle of a 3-cycle ch0 pulse, window [1,3].
        add(0, 4'h1, 4'h0, 4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(1, 4'h1, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h1, 4'h0, 4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0001);
        add(0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // All channels width 2, window [2,2], then empty window [5,3].
        add(0, 4'hF, 4'h0, 4'h2, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'hF, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'hF, 4'hF, 4'h0, 16'h2222);
        add(0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'hF, 4'h0, 4'h5, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'hF, 4'h0, 4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h5, 4'h3, 4'h0, 4'hF, 4'h0, 4'h0, 16'h2222);
        add(0, 4'h0, 4'h0, 4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // Back-to-back 1 0 1 0 on ch1, window [1,1].
        add(0, 4'h2, 4'h0, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 16'h0010);
        add(0, 4'h2, 4'h0, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 16'h0010);
        // min_w=0 behaves like min_w=1.
        add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0000);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0001);
        add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            a     = vecs[i].a;
            pol   = vecs[i].pol;
            min_w = vecs[i].mn;
            max_w = vecs[i].mx;
            #2;
            check_all(i, vecs[i].er, vecs[i].ef, vecs[i].ed, vecs[i].et, vecs[i].ew);
        end

        // 12-cycle ch2 pulse saturates: width 9, too_long, no detect even
        // with max_w above the saturation value.
        run_pulse(2, 12, 4'd1, 4'd15, 1'b0, 1'b1, 4'd9, 1000);
        // 10-cycle pulse with window [1,1]: counter must not wrap into the window.
        run_pulse(2, 10, 4'd1, 4'd1, 1'b0, 1'b1, 4'd9, 2000);
        // Exactly MAX_W is the longest exact width and is still detectable.
        run_pulse(2, 8, 4'd8, 4'd8, 1'b1, 1'b0, 4'd8, 3000);
        // MAX_W+... boundary: 9-cycle pulse saturates.
        run_pulse(0, 9, 4'd1, 4'd9, 1'b0, 1'b1, 4'd9, 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_width_detector.md
# multi_pulse_width_detector

Per-channel pulse-width classifier for N_CH independent single-bit inputs. It generalises the fixed one-cycle (010) pulse detector: a runtime-programmable window [min_w, max_w] sets which widths are accepted, and each channel has a selectable polarity. It also reports edges, the measured width, and over-length pulses. It sits next to the existing edge detectors in the sequential basics library and feeds event counters and debouncer stages.

## Interface
- N_CH, default 4: number of independent input channels.
- MAX_W, default 8: largest measurable pulse width in cycles. Widths above MAX_W saturate to MAX_W+1.
- CNT_W, default $clog2(MAX_W+2): width of the per-channel counter and of the width fields.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- a  in  N_CH  raw channel inputs, synchronous to clk.
- pol  in  N_CH  per-channel polarity. 0 means a pulse is high-going (0 1..1 0); 1 means low-going (1 0..0 1).
- min_w  in  CNT_W  minimum accepted width, shared by all channels.
- max_w  in  CNT_W  maximum accepted width, shared by all channels.
- rise  out  N_CH  pulse start: the effective input has just become active.
- fall  out  N_CH  pulse end: the effective input has just become inactive.
- detected  out  N_CH  a pulse ended this cycle and its width is inside the window.
- too_long  out  N_CH  a pulse ended this cycle and its width saturated (more than MAX_W).
- width  out  N_CH*CNT_W  measured width of the ending pulse. Channel i uses bits [i*CNT_W +: CNT_W].

## Operation
- Effective input per channel: b[i] = a[i] ^ pol[i].
- State per channel:
  - b_r[i]: previous b.
  - cnt[i]: number of consecutive active cycles up to and including the previous cycle.
- Update on each clk:
  - rst=1: b_r <= 0 and cnt <= 0 for every channel. After reset the line is treated as inactive, so a pulse starting in the first cycle after reset counts.
  - rst=0, b[i]=1: cnt[i] <= min(cnt[i]+1, MAX_W+1). The counter saturates and never wraps.
  - rst=0, b[i]=0: cnt[i] <= 0.
  - b_r[i] <= b[i] in both non-reset cases.
- Outputs, combinational from the state and the current inputs:
  - rise[i] = b[i] & ~b_r[i].
  - fall[i] = ~b[i] & b_r[i].
  - width field i = fall[i] ? cnt[i] : 0.
  - too_long[i] = fall[i] & (cnt[i] == MAX_W+1).
  - detected[i] = fall[i] & ~too_long[i] & (cnt[i] >= min_w) & (cnt[i] <= max_w).
- Window rules:
  - min_w is compared as given. Since cnt ≥ 1 whenever fall is high, min_w=0 behaves exactly like min_w=1.
  - If min_w > max_w, no pulse is ever detected; fall, width and too_long still operate.
  - max_w ≥ MAX_W+1 never accepts a saturated pulse, because too_long masks it.
- Channels are fully independent. Any combination of channels may assert in the same cycle.
- Changing pol[i] is equivalent to inverting a[i] that cycle and can create a real edge on the effective input. Software changes pol only while the channel is idle.
- min_w and max_w are evaluated only in the fall cycle. Changing them mid-pulse is legal and affects only pulses ending after the change.

## Timing
- Latency: 0 cycles from the sample that ends a pulse. detected, fall, width and too_long assert combinationally in the cycle where b first reads inactive, then drop the next cycle.
- Each output pulse is exactly one cycle wide per event.
- rise asserts in the first active cycle.
- Reset values while rst=1: all outputs are 0 regardless of a, because b_r=0 kills fall.
  - rise may follow b while rst=1; consumers ignore outputs during reset.
- Reset mid-pulse: the pulse is discarded. If b is still active after rst drops, counting restarts at 1 and rise reasserts.
- Back-to-back pulses with a single inactive cycle between them (1 0 1 0) are measured independently; cnt clears in the gap cycle.
- Minimum width is 1 cycle; maximum exact width is MAX_W.

## Test plan
- N_CH=4, MAX_W=8, min_w=max_w=1, pol=0. Drive ch0 with 0 1 0 → rise in cycle 1; fall, detected[0]=1 and width0=1 in cycle 2; all other outputs 0.
- min_w=2, max_w=4. Drive ch1 pulses of width 1, 3 and 5 → detected[1] only for the width-3 pulse. fall[1] for all three, with width1 = 1, 3 and 5 respectively.
- Drive ch2 high for 12 cycles, then low → width2=9, too_long[2]=1, detected[2]=0. Check cnt does not wrap, e.g. no detect on a 10-cycle pulse with min_w=1, max_w=1.
- pol[3]=1, a[3]=1 1 0 0 1 with window [2,2] → detected[3] in the cycle a[3] returns to 1, width3=2. The same waveform with pol[3]=0 produces no detect on ch3.
- Assert rst for 1 cycle in the middle of a 3-cycle ch0 pulse → no fall or detect for the interrupted pulse; the remainder is measured as a fresh pulse.
- All 4 channels get a width-2 pulse on the same cycles with window [2,2] → detected=4'b1111 in a single cycle. Then set min_w=5, max_w=3 and repeat → detected=0 while fall=4'b1111.
